keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 Parameter SCAN_DIV, default 4: clock cycles each column is driven before the scan advances (minimum 2).
REQ-002 Parameter DEBOUNCE_CYCLES, default 8: consecutive stable samples required to accept a press or a release (minimum 1).
REQ-003 clk  input  1  single system clock; all state updates on the rising edge.
REQ-004 nRST  input  1  reset, asynchronous and active-low.
REQ-005 RowIn  input  4  keypad rows, active-low; bit r low means a key in row r of the driven column is closed.
REQ-006 ColOut  output  4  keypad column drive, active-low one-hot; column c is driven when ColOut == ~(4'b0001 << c).
REQ-007 key_read  input  1  consumer acknowledge; sampled only in VALID.
REQ-008 key_valid  output  1  key_code holds an accepted, debounced key.
REQ-009 key_code  output  4  key index = row*4 + col (0..15).
REQ-010 key_pressed  output  1  high in every state except SCAN (status/LED).

Function
REQ-011 The FSM SHALL have exactly the states SCAN, DEBOUNCE, VALID and RELEASE.
REQ-012 SCAN: ColOut drives column col; a divider counts 0..SCAN_DIV-1, and col increments at terminal count, wrapping 3 -> 0.
REQ-013 SCAN: when any bit of the sampled row vector is low, the block SHALL latch row (lowest-index low bit wins) and col, clear the debounce counter, freeze ColOut, and enter DEBOUNCE on the next edge.
REQ-014 DEBOUNCE: each cycle the latched row bit is low, the counter increments; on reaching DEBOUNCE_CYCLES the FSM enters VALID.
REQ-015 DEBOUNCE: a high sample on the latched row SHALL return the FSM to SCAN, with the divider cleared and col unchanged (bounce rejection).
REQ-016 VALID: key_valid = 1 and key_code = row*4 + col, both stable until the handshake completes.
REQ-017 VALID: key_read = 1 at a rising edge SHALL complete the handshake, clear key_valid on that edge, and enter RELEASE.
REQ-018 VALID: the key may be released before key_read arrives; the press is still held and reported until acknowledged.
REQ-019 key_read outside VALID SHALL be ignored.
REQ-020 RELEASE: ColOut stays frozen; DEBOUNCE_CYCLES consecutive high samples of the latched row return the FSM to SCAN, with col advanced by one (wrapping) and the divider cleared.
REQ-021 RELEASE: any low sample of the latched row SHALL clear the release counter; no further key is reported until a full release.
REQ-022 Keys other than the latched one SHALL be ignored in DEBOUNCE, VALID and RELEASE.
REQ-023 Latency SHALL be DEBOUNCE_CYCLES+1 cycles from the first sampled low to key_valid high, plus the synchronizer delay when that is compiled in.

Reset
REQ-024 While nRST = 0 the block SHALL hold state SCAN, col = 0, ColOut = 4'b1110, key_valid = 0, key_code = 0, key_pressed = 0, and all counters and synchronizer flops at their cleared values.
REQ-025 Reset asserted in any state SHALL take effect immediately, without waiting for a clock edge, and abandon any pending key; scanning SHALL resume at column 0 after deassertion.

Configuration
REQ-026 Macro KEYPAD_ROW_SYNC_EN defined: RowIn SHALL pass through a two-flop synchronizer (reset to 4'b1111) before the FSM samples it, adding 2 cycles of latency.
REQ-027 KEYPAD_ROW_SYNC_EN undefined: the FSM SHALL sample RowIn directly; all other behaviour SHALL be identical.

Verification
REQ-028 Reset, then hold RowIn = 1111 for 40 cycles -> ColOut cycles 1110, 1101, 1011, 0111, 1110, each held 4 cycles; key_valid stays 0.
REQ-029 Drive RowIn = 1101 while ColOut = 1011, hold it; pulse key_read after key_valid rises -> key_code = 6 and key_valid = 1 exactly 9 cycles after the first low sample (no sync); key_valid falls on the key_read edge.
REQ-030 Drive RowIn = 1110 for 3 cycles in column 0, then 1111 -> FSM returns to SCAN and key_valid never asserts.
REQ-031 Press key 12 (row 3, column 0); keep key_read = 0 and release the key -> key_valid stays 1 with key_code = 12 until key_read; then RELEASE completes after 8 high cycles and scanning resumes at ColOut = 1101.
REQ-032 Press key 15 and acknowledge it, while keeping RowIn = 0111 held -> no second key_valid until RowIn returns to 1111 for 8 cycles.
REQ-033 Assert nRST mid-VALID with key_code = 11 -> key_valid = 0, key_code = 0 and ColOut = 1110 immediately; repeat REQ-029 with KEYPAD_ROW_SYNC_EN defined -> latency 11 cycles.

Source files
------------

// File: rtl/keypad_scanner.sv
// rtl/keypad_scanner.sv - 4x4 matrix keypad scanner with debounce and valid/read handshake (optional row synchronizer: KEYPAD_ROW_SYNC_EN)
module keypad_scanner #(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic       clk,
    input  logic       nRST,
    input  logic [3:0] RowIn,
    output logic [3:0] ColOut,
    input  logic       key_read,
    output logic       key_valid,
    output logic [3:0] key_code,
    output logic       key_pressed
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        VALID    = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [1:0]      col, col_n;
    logic [DW-1:0]   div, div_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [1:0]      row_lat, row_n;
    logic [3:0]      code_r, code_n;

    logic [3:0]      rows;
    logic [1:0]      hit_row;
    logic            any_low;
    logic            row_bit;

`ifdef KEYPAD_ROW_SYNC_EN
    logic [3:0] sync1;
    logic [3:0] sync2;

    // Two-flop synchronizer; idle value is "no key" so reset cannot fake a press
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            sync1 <= RowIn;
            sync2 <= sync1;
        end
    end

    assign rows = sync2;
`else
    assign rows = RowIn;
`endif

    assign any_low = ~&rows;
    assign row_bit = rows[row_lat];

    // Lowest-index closed row wins when several rows are low together
    always_comb begin
        hit_row = 2'd3;
        if (!rows[0]) begin
            hit_row = 2'd0;
        end else if (!rows[1]) begin
            hit_row = 2'd1;
        end else if (!rows[2]) begin
            hit_row = 2'd2;
        end
    end

    // State and datapath registers; reset abandons any pending key
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state   <= SCAN;
            col     <= 2'd0;
            div     <= '0;
            cnt     <= '0;
            row_lat <= 2'd0;
            code_r  <= 4'd0;
        end else begin
            state   <= state_n;
            col     <= col_n;
            div     <= div_n;
            cnt     <= cnt_n;
            row_lat <= row_n;
            code_r  <= code_n;
        end
    end

    // Next-state logic: scan columns, debounce the latched key, hold it until read, wait for release
    always_comb begin
        state_n = state;
        col_n   = col;
        div_n   = div;
        cnt_n   = cnt;
        row_n   = row_lat;
        code_n  = code_r;
        case (state)
            SCAN: begin
                if (any_low) begin
                    // Column is frozen from here until the key is fully released or rejected
                    row_n   = hit_row;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end else if (div == DIV_LAST) begin
                    div_n = '0;
                    col_n = col + 2'd1;
                end else begin
                    div_n = div + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (row_bit) begin
                    // Bounce: resume scanning on the same column with a fresh dwell
                    state_n = SCAN;
                    div_n   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_n = VALID;
                    code_n  = {row_lat, col};
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            VALID: begin
                // The press is held even if the key opens before the consumer reads it
                if (key_read) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                end
            end
            RELEASE: begin
                if (!row_bit) begin
                    cnt_n = '0;
                end else if (cnt == CNT_LAST) begin
                    // Advance past this column so a still-bouncing key is not rescanned first
                    state_n = SCAN;
                    col_n   = col + 2'd1;
                    div_n   = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = SCAN;
            end
        endcase
    end

    assign ColOut      = ~(4'b0001 << col);
    assign key_valid   = (state == VALID);
    assign key_code    = code_r;
    assign key_pressed = (state != SCAN);

endmodule

// File: tb/tb_keypad_scanner.sv
// tb/tb_keypad_scanner.sv - directed self-checking bench for keypad_scanner (honours KEYPAD_ROW_SYNC_EN)
module tb_keypad_scanner;

`ifdef KEYPAD_ROW_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    localparam int LAT = 8 + 1 + SYNC;

    logic       clk;
    logic       nRST;
    logic [3:0] RowIn;
    logic [3:0] ColOut;
    logic       key_read;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_pressed;

    int checks   = 0;
    int failures = 0;

    keypad_scanner #(
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk         (clk),
        .nRST        (nRST),
        .RowIn       (RowIn),
        .ColOut      (ColOut),
        .key_read    (key_read),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .key_pressed (key_pressed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] col_drive(input int c);
        col_drive = ~(4'b0001 << c);
    endfunction

    // Returns just after the edge on which the scan moves onto column c
    task automatic wait_col(input int c);
        logic [3:0] prev;
        int n;
        n = 0;
        do begin
            prev = ColOut;
            tick();
            n++;
        end while (!(ColOut == col_drive(c) && prev != col_drive(c)) && n < 40);
        chk("wait_col_in_time", 32'(n < 40), 32'd1);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!key_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_read(input string tag);
        key_read = 1'b1;
        tick();
        chk({tag, "_valid_drop_on_read"}, 32'(key_valid), 32'd0);
        chk({tag, "_pressed_in_release"}, 32'(key_pressed), 32'd1);
        key_read = 1'b0;
    endtask

    task automatic release_check(input string tag, input int extra, input logic [3:0] frozen,
                                 input logic [3:0] next_col);
        repeat (extra) tick();
        chk({tag, "_still_release"}, 32'(key_pressed), 32'd1);
        chk({tag, "_col_frozen"}, 32'(ColOut), 32'(frozen));
        tick();
        chk({tag, "_back_to_scan"}, 32'(key_pressed), 32'd0);
        chk({tag, "_col_advanced"}, 32'(ColOut), 32'(next_col));
    endtask

    initial begin
        int n;
        logic seen;

        nRST     = 1'b0;
        RowIn    = 4'b1111;
        key_read = 1'b0;
        #3;
        chk("rst_colout", 32'(ColOut), 32'h e);
        chk("rst_valid", 32'(key_valid), 32'd0);
        chk("rst_code", 32'(key_code), 32'd0);
        chk("rst_pressed", 32'(key_pressed), 32'd0);
        tick();
        tick();
        nRST = 1'b1;

        // Idle scan: each column driven for 4 cycles, wrapping
        for (int t = 1; t <= 40; t++) begin
            tick();
            chk($sformatf("idle_col_t%0d", t), 32'(ColOut), 32'(col_drive((t / 4) % 4)));
            chk($sformatf("idle_valid_t%0d", t), 32'(key_valid), 32'd0);
        end

        // Key 6: row 1 in column 2, held through the handshake
        wait_col(2);
        RowIn = 4'b1101;
        tick();
        chk("k6_pressed_after_first", 32'(key_pressed), 32'(SYNC == 0));
        chk("k6_valid_early", 32'(key_valid), 32'd0);
        wait_valid(n);
        chk("k6_latency", 32'(n), 32'(LAT));
        chk("k6_code", 32'(key_code), 32'd6);
        repeat (3) tick();
        chk("k6_valid_hold", 32'(key_valid), 32'd1);
        chk("k6_code_hold", 32'(key_code), 32'd6);
        pulse_read("k6");
        RowIn = 4'b1111;
        release_check("k6", 7 + SYNC, col_drive(2), col_drive(3));

        // Bounce in column 0: three low cycles then open; key_read outside VALID is ignored
        wait_col(0);
        key_read = 1'b1;
        RowIn = 4'b1110;
        repeat (3) tick();
        chk("bounce_in_debounce", 32'(key_pressed), 32'd1);
        RowIn = 4'b1111;
        repeat (SYNC) tick();
        tick();
        chk("bounce_back_to_scan", 32'(key_pressed), 32'd0);
        chk("bounce_col_kept", 32'(ColOut), 32'(col_drive(0)));
        repeat (3) tick();
        chk("bounce_div_cleared_a", 32'(ColOut), 32'(col_drive(0)));
        tick();
        chk("bounce_div_cleared_b", 32'(ColOut), 32'(col_drive(1)));
        key_read = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            if (key_valid) seen = 1'b1;
        end
        chk("bounce_no_valid", 32'(seen), 32'd0);

        // Key 12: released before the read, still reported until acknowledged
        wait_col(0);
        RowIn = 4'b0111;
        tick();
        wait_valid(n);
        chk("k12_latency", 32'(n), 32'(LAT));
        chk("k12_code", 32'(key_code), 32'd12);
        RowIn = 4'b1111;
        seen = 1'b0;
        repeat (12) begin
            tick();
            if (!key_valid) seen = 1'b1;
        end
        chk("k12_held_after_open", 32'(seen), 32'd0);
        chk("k12_code_after_open", 32'(key_code), 32'd12);
        pulse_read("k12");
        release_check("k12", 7, col_drive(0), col_drive(1));

        // Key 15 held after acknowledge: no repeat until a full release
        wait_col(3);
        RowIn = 4'b0111;
        tick();
        wait_valid(n);
        chk("k15_latency", 32'(n), 32'(LAT));
        chk("k15_code", 32'(key_code), 32'd15);
        pulse_read("k15");
        seen = 1'b0;
        repeat (30) begin
            tick();
            if (key_valid) seen = 1'b1;
        end
        chk("k15_no_repeat", 32'(seen), 32'd0);
        chk("k15_still_pressed", 32'(key_pressed), 32'd1);
        RowIn = 4'b1111;
        release_check("k15", 7 + SYNC, col_drive(3), col_drive(0));

        // Key 11 then asynchronous reset while VALID
        wait_col(3);
        RowIn = 4'b1011;
        tick();
        wait_valid(n);
        chk("k11_latency", 32'(n), 32'(LAT));
        chk("k11_code", 32'(key_code), 32'd11);
        #2;
        nRST  = 1'b0;
        RowIn = 4'b1111;
        #1;
        chk("arst_valid", 32'(key_valid), 32'd0);
        chk("arst_code", 32'(key_code), 32'd0);
        chk("arst_colout", 32'(ColOut), 32'h e);
        chk("arst_pressed", 32'(key_pressed), 32'd0);
        tick();
        nRST = 1'b1;
        repeat (3) tick();
        chk("arst_resume_col0", 32'(ColOut), 32'(col_drive(0)));
        tick();
        chk("arst_resume_col1", 32'(ColOut), 32'(col_drive(1)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
